// File: rtl/pipeline_mac_acc_pkg.sv
// Shared types and default widths for the multiplier-output accumulator.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package pipeline_mac_pkg;

    localparam int PW_DEF      = 128;
    localparam int AW_DEF      = 136;
    localparam int CW_DEF      = 8;
    localparam int MUL_LAT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_mac_acc_if.sv
// Burst control, product stream and result bundle between the multiplier side and the accumulator.
// Latency: none (wires only).
// Backpressure: none; the product stream is free-running and aligned by the consumer.
interface pipeline_mac_acc_if
    import pipeline_mac_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) ();

    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic [PW-1:0] prod;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          busy;
    logic          ovf;

    modport master (
        output start,
        output len,
        output in_valid,
        output prod,
        input  acc_out,
        input  acc_valid,
        input  busy,
        input  ovf
    );

    modport slave (
        input  start,
        input  len,
        input  in_valid,
        input  prod,
        output acc_out,
        output acc_valid,
        output busy,
        output ovf
    );

endinterface

// File: rtl/pipeline_mac_acc_valid_delay_line.sv
// Shift register that delays a valid strobe by DEPTH cycles to line it up with pipelined data.
// Latency: DEPTH cycles from in_valid to p_valid.
// Backpressure: none; shifts every cycle regardless of consumer state.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic p_valid
);

    logic [DEPTH-1:0] sr_q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= in_valid;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= {sr_q[DEPTH-2:0], in_valid};
                end
            end
        end
    endgenerate

    assign p_valid = sr_q[DEPTH-1];

endmodule

// File: rtl/pipeline_mac_acc.sv
// Sums a programmed-length burst of multiplier products; MAC_SATURATE_EN clamps on overflow instead of wrapping.
// Latency: result and acc_valid pulse appear 2 cycles after the last product is sampled.
// Backpressure: none; accepts a product every cycle, start ignored while busy.
module pipeline_mac_acc
    import pipeline_mac_pkg::*;
#(
    parameter int PW      = PW_DEF,
    parameter int AW      = AW_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    pipeline_mac_acc_if.slave bus
);

    if (AW < PW) begin : g_bad_aw
        $error("pipeline_mac_acc: AW must be >= PW");
    end
    if (MUL_LAT < 1) begin : g_bad_lat
        $error("pipeline_mac_acc: MUL_LAT must be >= 1");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] len_q, len_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] acc_out_q;
    logic          acc_valid_q;

    logic          p_valid;
    logic [AW:0]   sum;
    logic          carry;
    logic [CW-1:0] count_inc;

    // in_valid travels alongside the multiplier pipeline so p_valid marks the cycle its product lands
    valid_delay_line #(
        .DEPTH (MUL_LAT)
    ) u_valid_delay (
        .clk      (clk),
        .rst_n    (reset),
        .in_valid (bus.in_valid),
        .p_valid  (p_valid)
    );

    assign sum       = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, bus.prod};
    assign carry     = sum[AW];
    assign count_inc = count_q + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                // products still draining from a previous burst are ignored here
                if (bus.start) begin
                    len_d   = bus.len;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (p_valid) begin
                    count_d = count_inc;
                    ovf_d   = ovf_q | carry;
`ifdef MAC_SATURATE_EN
                    // once clamped, the sum stays pinned for the rest of the burst
                    acc_d = (ovf_q || carry) ? '1 : sum[AW-1:0];
`else
                    acc_d = sum[AW-1:0];
`endif
                    if (count_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            acc_valid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                acc_out_q <= acc_q;
            end
        end
    end

    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipeline_mac_acc.sv
// Randomized bench for pipeline_mac_acc against a burst-level sum model (honours MAC_SATURATE_EN).
// Latency: expects the result pulse MUL_LAT+2 cycles after the last counted issue.
// Backpressure: none modelled; drives a free-running multiplier delay line.
module tb_pipeline_mac_acc;

    localparam int PW      = 128;
    localparam int AW      = 130;
    localparam int MUL_LAT = 4;
    localparam int CW      = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_mac_acc_if #(.PW(PW), .AW(AW), .CW(CW)) bus ();

    pipeline_mac_acc #(
        .PW      (PW),
        .AW      (AW),
        .MUL_LAT (MUL_LAT),
        .CW      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [PW-1:0] hist [MUL_LAT];
    logic [PW-1:0] last_pv;
    logic          busy_at [int];

    int            pulses;
    int            pulse_cyc;
    logic [AW-1:0] got_acc;
    logic          got_ovf;

    logic [PW-1:0] bq_p [$];
    int            bq_g [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: observe this cycle's outputs, then drive this cycle's inputs.
    task automatic tick(input logic st, input logic [CW-1:0] ln, input logic iv, input logic [PW-1:0] pv);
        @(negedge clk);
        cyc++;
        busy_at[cyc] = bus.busy;
        if (bus.acc_valid === 1'b1) begin
            pulses++;
            pulse_cyc = cyc;
            got_acc   = bus.acc_out;
            got_ovf   = bus.ovf;
        end
        for (int i = MUL_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0]      = last_pv;
        last_pv      = pv;
        bus.prod     = hist[MUL_LAT-1];
        bus.start    = st;
        bus.len      = ln;
        bus.in_valid = iv;
    endtask

    function automatic logic [PW-1:0] rnd_prod();
        logic [PW-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(3) == 0) v = ~(PW'($urandom_range(255)));
        return v;
    endfunction

    // pre>0 issues one product pre cycles before start, so it lands pre cycles... MUL_LAT-pre after start.
    task automatic run_burst(input string tag, input int ln, input int pre, input bit sb);
        logic [255:0] tot;
        logic [255:0] exp_acc;
        logic         exp_ovf;
        int           s, c_last, exp_cyc, bad_busy;
        tot = '0;
        if (pre > 0) begin
            tick(1'b0, '0, 1'b1, rnd_prod());
            repeat (pre - 1) tick(1'b0, '0, 1'b0, rnd_prod());
        end
        pulses  = 0;
        got_acc = '0;
        got_ovf = 1'b0;
        tick(1'b1, CW'(ln), 1'b0, rnd_prod());
        s      = cyc;
        c_last = s;
        for (int k = 0; k < bq_p.size(); k++) begin
            for (int g = 0; g < bq_g[k]; g++)
                tick(sb && (cyc + 1 == s + 2), CW'($urandom_range(1, 255)), 1'b0, rnd_prod());
            tick(sb && (cyc + 1 == s + 2), CW'($urandom_range(1, 255)), 1'b1, bq_p[k]);
            if (k < ln) begin
                tot = tot + 256'(bq_p[k]);
                if (k == ln - 1) c_last = cyc;
            end
        end
        repeat (MUL_LAT + 6) tick(sb && (cyc + 1 == s + 2), CW'(3), 1'b0, rnd_prod());

        exp_ovf = |tot[255:AW];
        exp_acc = 256'(tot[AW-1:0]);
`ifdef MAC_SATURATE_EN
        if (exp_ovf) exp_acc = (256'(1) << AW) - 256'(1);
`endif
        exp_cyc  = (ln == 0) ? s + 2 : c_last + MUL_LAT + 2;
        bad_busy = 0;
        for (int c = s + 1; c < exp_cyc; c++) if (busy_at[c] !== 1'b1) bad_busy++;
        if (busy_at[exp_cyc] !== 1'b0) bad_busy++;

        check({tag, "_pulses"}, 256'(pulses), 256'(1));
        check({tag, "_acc"}, 256'(got_acc), exp_acc);
        check({tag, "_ovf"}, 256'(got_ovf), 256'(exp_ovf));
        check({tag, "_lat"}, 256'(pulse_cyc), 256'(exp_cyc));
        check({tag, "_busy"}, 256'(bad_busy), 256'(0));
        check({tag, "_hold"}, 256'(bus.acc_out), exp_acc);
        bq_p.delete();
        bq_g.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] full;
        logic [PW-1:0] ff64;
        int            ln, n;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.prod     = '0;
        last_pv      = '0;
        for (int i = 0; i < MUL_LAT; i++) hist[i] = '0;
        #2 reset = 1'b0;
        repeat (3) tick(1'b0, '0, 1'b0, '0);
        check("rst_acc_out", 256'(bus.acc_out), 256'(0));
        check("rst_acc_valid", 256'(bus.acc_valid), 256'(0));
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_ovf", 256'(bus.ovf), 256'(0));
        reset = 1'b1;
        repeat (2) tick(1'b0, '0, 1'b0, '0);

        // basic back-to-back burst
        repeat (3) begin bq_p.push_back(PW'(114904361)); bq_g.push_back(0); end
        run_burst("basic", 3, 0, 1'b0);
        check("basic_const", 256'(got_acc), 256'(344713083));

        // gapped issue, 3 idle cycles between products
        bq_p.push_back(PW'(6));  bq_g.push_back(0);
        bq_p.push_back(PW'(35)); bq_g.push_back(3);
        run_burst("gap", 2, 0, 1'b0);
        check("gap_const", 256'(got_acc), 256'(41));

        // zero length with a stray product landing in DONE
        run_burst("zero", 0, 3, 1'b0);

        // start and p_valid together in IDLE
        bq_p.push_back(PW'(1000)); bq_g.push_back(1);
        bq_p.push_back(PW'(2000)); bq_g.push_back(0);
        run_burst("same", 2, 4, 1'b0);

        // second start during ACC is ignored
        for (int k = 0; k < 4; k++) begin bq_p.push_back(rnd_prod()); bq_g.push_back(k); end
        run_burst("sbusy", 4, 0, 1'b1);

        // overflow past 2^AW
        ff64 = PW'(64'hFFFF_FFFF_FFFF_FFFF);
        full = ff64 * ff64;
        repeat (5) begin bq_p.push_back(full); bq_g.push_back(0); end
        run_burst("ovf", 5, 0, 1'b0);
        check("ovf_flag", 256'(got_ovf), 256'(1));

        // reset two cycles into a len=4 burst
        pulses = 0;
        tick(1'b1, CW'(4), 1'b1, PW'(7));
        tick(1'b0, CW'(4), 1'b1, PW'(9));
        tick(1'b0, CW'(4), 1'b1, PW'(11));
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 256'(bus.busy), 256'(0));
        check("mid_rst_acc_out", 256'(bus.acc_out), 256'(0));
        check("mid_rst_acc_valid", 256'(bus.acc_valid), 256'(0));
        check("mid_rst_ovf", 256'(bus.ovf), 256'(0));
        repeat (2) tick(1'b0, CW'(4), 1'b1, PW'(13));
        reset = 1'b1;
        repeat (3) tick(1'b0, CW'(4), 1'b1, PW'(15));
        repeat (MUL_LAT + 4) tick(1'b0, CW'(4), 1'b0, PW'(0));
        check("mid_rst_no_pulse", 256'(pulses), 256'(0));
        check("mid_rst_busy_after", 256'(bus.busy), 256'(0));

        bq_p.push_back(PW'(21)); bq_g.push_back(0);
        bq_p.push_back(PW'(22)); bq_g.push_back(2);
        run_burst("post_rst", 2, 0, 1'b0);

        // randomized bursts
        for (int b = 0; b < 24; b++) begin
            ln = $urandom_range(0, 10);
            n  = ln + $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                bq_p.push_back(rnd_prod());
                bq_g.push_back(($urandom_range(2) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_burst($sformatf("rnd%0d", b), ln,
                      (ln == 0) ? 3 * $urandom_range(1) : 4 * $urandom_range(1),
                      (ln > 0) && ($urandom_range(1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
